// File: rtl/decoder_pkg.sv
// Shared definitions for the decoder_scan block: input mode codes, FSM states
// and the binary-to-one-hot helper.
package decoder_pkg;

   localparam int unsigned MAX_IN_W  = 8;
   localparam int unsigned MAX_OUT_W = 1 << MAX_IN_W;

   typedef enum logic [1:0] {
      MODE_HOLD  = 2'b00,
      MODE_PULSE = 2'b01,
      MODE_SCAN  = 2'b10,
      MODE_RSVD  = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HOLD,
      ST_PULSE,
      ST_SCAN
   } state_t;

   // Result is MAX_OUT_W wide; callers size-cast it down to their own OUT_W.
   function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_IN_W-1:0] code);
      logic [MAX_OUT_W-1:0] v;
      v       = '0;
      v[code] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/decoder_scan_tick_counter.sv
// Down-counter that reloads to LEN-1 and flags the cycle its count reaches zero
// while running, giving one terminal-count pulse every LEN running cycles.
module tick_counter #(
   parameter int unsigned LEN = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic load_i,
   input  logic run_i,
   output logic tc_o
);

   localparam int unsigned   CW     = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(LEN - 1);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (load_i) begin
         count_d = RELOAD;
      end else if (run_i) begin
         count_d = (count_q == '0) ? RELOAD : count_q - CW'(1);
      end
   end

   assign tc_o = run_i && (count_q == '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/decoder_scan.sv
// Registered binary-to-one-hot decoder with valid/ready input and HOLD, PULSE
// and SCAN output modes.
module decoder_scan
   import decoder_pkg::*;
#(
   parameter int unsigned IN_W      = 3,
   parameter int unsigned PULSE_LEN = 4,
   parameter int unsigned SCAN_DIV  = 8
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst_n,
   input  logic                    en,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [IN_W-1:0]         in_code,
   input  logic [1:0]              in_mode,
   output logic [(1 << IN_W)-1:0]  out,
   output logic                    out_valid,
   output logic [IN_W-1:0]         code_q
);

   localparam int unsigned OUT_W = 1 << IN_W;

   state_t            state_q, state_d;
   logic [IN_W-1:0]   code_d;
   logic [OUT_W-1:0]  out_d;
   logic              started_q;
   logic              xfer;
   logic              pulse_tc, scan_tc;
   mode_t             mode;

   assign mode     = mode_t'(in_mode);
   // started_q keeps in_ready low from reset release until the first edge.
   assign in_ready = en && started_q && (state_q != ST_PULSE);
   assign xfer     = in_valid && in_ready;

   tick_counter #(.LEN(PULSE_LEN)) u_pulse_timer (
      .clk_i   (sys_clk),
      .rst_ni  (sys_rst_n),
      .clear_i (!en),
      .load_i  (xfer && (mode == MODE_PULSE)),
      .run_i   (state_q == ST_PULSE),
      .tc_o    (pulse_tc)
   );

   tick_counter #(.LEN(SCAN_DIV)) u_scan_div (
      .clk_i   (sys_clk),
      .rst_ni  (sys_rst_n),
      .clear_i (!en),
      .load_i  (xfer),
      .run_i   (state_q == ST_SCAN),
      .tc_o    (scan_tc)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= ST_IDLE;
         code_q    <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         started_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         code_q    <= code_d;
         out       <= out_d;
         out_valid <= |out_d;
         started_q <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      if (!en) begin
         state_d = ST_IDLE;
      end else if (xfer) begin
         code_d = in_code;
         case (mode)
            MODE_PULSE: state_d = ST_PULSE;
            MODE_SCAN:  state_d = ST_SCAN;
            default:    state_d = ST_HOLD;
         endcase
      end else begin
         case (state_q)
            ST_PULSE: if (pulse_tc) state_d = ST_IDLE;
            ST_SCAN:  if (scan_tc)  code_d  = code_q + IN_W'(1);
            default:  ;
         endcase
      end
   end

   // Outputs are decoded from the next state and registered with it.
   always_comb begin
      out_d = '0;
      if (state_d != ST_IDLE) begin
         out_d = OUT_W'(onehot(MAX_IN_W'(code_d)));
      end
   end

endmodule

// File: doc/decoder_scan.md
# decoder_scan

Parametrised, registered binary-to-one-hot decoder, the successor to the fixed 3-to-8 decoder. It generalises the input width and adds a valid/ready input handshake, registered outputs and three output modes: HOLD (latched one-hot), PULSE (one-hot for a programmable number of cycles) and SCAN (auto-stepping one-hot walk for LED/digit scanning). It sits between control logic and display/select lines.

## Interface
- IN_W, 3, code width; OUT_W = 2**IN_W is a derived localparam, not overridable
- PULSE_LEN, 4, cycles the one-hot stays asserted in PULSE mode, ≥1
- SCAN_DIV, 8, cycles per scan step in SCAN mode, ≥1

Ports:
- sys_clk  in  1  clock, rising edge
- sys_rst_n  in  1  asynchronous, active-low reset
- en  in  1  block enable; 0 forces outputs low
- in_valid  in  1  code/mode offered
- in_ready  out  1  block can accept
- in_code  in  IN_W  binary code
- in_mode  in  2  00 HOLD, 01 PULSE, 10 SCAN, 11 reserved (treated as HOLD)
- out  out  OUT_W  one-hot or all-zero
- out_valid  out  1  out is non-zero
- code_q  out  IN_W  binary index currently driven on out

## Operation
- Handshake: a transfer occurs on a rising edge with in_valid & in_ready & en.
- FSM states: IDLE, HOLD, PULSE, SCAN. Reset state is IDLE.
- IDLE: out = 0, in_ready = en. A transfer goes to HOLD, PULSE or SCAN per in_mode.
- HOLD: out = 1 << code_q, held indefinitely. in_ready = en. A new transfer replaces code and mode.
- PULSE: out = 1 << code_q for exactly PULSE_LEN cycles, then IDLE with out = 0. in_ready = 0 throughout.
- SCAN: starts at the accepted code; code_q increments every SCAN_DIV cycles and wraps from OUT_W-1 to 0. in_ready = en. A new transfer restarts at the new code/mode with the step counter cleared.
- en deasserted in any state: next edge goes to IDLE, out = 0, counters cleared; the code and mode in flight are dropped.
- Simultaneous en=0 and in_valid: en wins, no transfer.
- Width rule: code_q is IN_W bits; wrap is the natural IN_W-bit overflow. Exactly one bit of out is set whenever out_valid = 1.

## Timing
- Reset (async assert, sync-released behaviour): out = 0, out_valid = 0, code_q = 0, in_ready = 0 while sys_rst_n low. in_ready = en from the first edge after release.
- Latency: 1 cycle. The code accepted at edge N appears on out/code_q after edge N.
- PULSE: out high for edges N..N+PULSE_LEN-1 outputs. in_ready returns high the cycle out returns to 0.
- SCAN: first step occurs SCAN_DIV cycles after acceptance. Each index is held for exactly SCAN_DIV cycles.
- All outputs are registered. There is no combinational path from inputs to out. in_ready depends combinationally on en and state only.
- Reset mid-PULSE/SCAN: outputs clear immediately (asynchronously). The FSM resumes in IDLE.

## Structure
- Shared package decoder_pkg: mode encodings (MODE_HOLD, MODE_PULSE, MODE_SCAN), FSM state typedef, onehot function (code → OUT_W vector).
- One sub-module: tick_counter (parametrised down-counter with load/clear, terminal-count pulse). Two instances are used: the PULSE_LEN timer and the SCAN_DIV step divider.
- Top contains the FSM, handshake and output registers.

## Test plan
- Reset then HOLD, IN_W=3: transfer code 5 → out = 8'b0010_0000 one cycle later, code_q = 5, held for 100 cycles; in_ready = 1.
- PULSE, PULSE_LEN=4: code 2 → out = 8'b0000_0100 for exactly 4 cycles, then 0; in_ready low for those 4 cycles. in_valid held high during the pulse is not accepted.
- SCAN, SCAN_DIV=2: code 6 → code_q sequence 6,6,7,7,0,0,1… (wrap checked); out stays one-hot each cycle.
- en dropped mid-SCAN → out = 0 next cycle, state IDLE. en re-raised → no output until a new transfer.
- sys_rst_n asserted mid-PULSE → out = 0 immediately without a clock edge. After release, mode 11 with code 3 behaves as HOLD (out = 8'b0000_1000).
- IN_W=4 instance: random code/mode sweep (≥1000 transfers) against a reference model; check the one-hot invariant and out_valid == |out.
